module_display_arbiter: RTL and testbench
=========================================

// Module: module_display_arbiter
// PURPOSE
// Shares the 8-digit 7-segment display between N_REQ requesters (counters, debug words, status).
// Sits between the requesters and module_seg7_control; digits_o drives display_i.
// Ownership changes are paced by the cathode-rate tick from module_clock_catodo.
// Round-robin arbitration with a minimum hold time and a one-cycle blank gap between owners.
// PARAMETERS
// N_REQ       4              number of requesters (2..8)
// HOLD_TICKS  10             minimum ownership, in tick_en_i pulses (>=1)
// BITS_HOLD   4              hold counter width, = $clog2(HOLD_TICKS+1)
// IDLE_DIGITS 32'h0000_0000  value shown when no owner (8 BCD nibbles)
// PORTS
// clk_10Mhz_i  in   1         system clock, 10 MHz
// reset_i      in   1         synchronous reset, active-high
// tick_en_i    in   1         one-cycle enable pulse, cathode rate
// req_i        in   N_REQ     request per requester, level; held until done
// digits_i     in   N_REQ*32  requester k drives bits [32k+31:32k]
// gnt_o        out  N_REQ     one-hot grant, registered
// valid_o      out  1         high while an owner is displayed
// digits_o     out  32        to module_seg7_control display_i
// BEHAVIOUR
// - Reset (sync, active-high, on any cycle, including mid-ownership):
//   - state=IDLE, gnt_o=0, valid_o=0, digits_o=IDLE_DIGITS.
//   - rr_ptr=0, hold_cnt=0.
// - FSM states: IDLE, OWN, GAP.
// - IDLE:
//   - If any req_i bit is set, pick the first requester at or above rr_ptr (wrap-around).
//   - Next edge: state=OWN, gnt_o=onehot(pick), valid_o=1, hold_cnt=0.
//   - Latency from req to gnt: 1 cycle.
// - OWN:
//   - digits_o <= digits_i[owner] every cycle (1-cycle registered latency).
//   - hold_cnt increments on tick_en_i and saturates at HOLD_TICKS.
// - Release from OWN happens when either:
//   - (a) req_i[owner]==0, at any time; early release is allowed, or
//   - (b) hold_cnt==HOLD_TICKS and another req_i bit is set.
// - On release, next edge:
//   - state=GAP, gnt_o=0, valid_o=0, digits_o=IDLE_DIGITS.
//   - rr_ptr=(owner+1) mod N_REQ.
// - A sole requester keeps ownership indefinitely after its hold expires; there is no self-preemption.
// - GAP: one cycle of break-before-make, then IDLE; arbitration uses req_i as sampled in IDLE.
// - Simultaneous events:
//   - tick_en_i in the same cycle the owner drops req: release wins; the tick is ignored.
//   - hold expiry reached in the same cycle a new request arrives: release on that edge.
// - Requests raised during OWN or GAP are not lost; being level requests, they are served in rr order.
// - digits_i of non-owners is ignored; nibbles pass through unmodified, with no BCD checking.
// - Worst-case wait for requester k while others stay busy:
//   (N_REQ-1)*(HOLD_TICKS tick periods + 2 cycles).
// STRUCTURE
// - package display_pkg:
//   - DIGITS_W=32, NIBBLES=8.
//   - typedef enum logic[1:0] {IDLE, OWN, GAP} arb_state_t.
//   - IDLE_DIGITS default.
// - sub-module module_rr_picker (combinational):
//   - inputs req, ptr; outputs any_o and idx_o (first set bit at or above ptr, wrapping).
// - All outputs come straight from flops; no combinational path from req_i to gnt_o.
// TESTING
// Bench setup: N_REQ=4, HOLD_TICKS=3, tick_en_i one pulse every 4 clocks, digits_i[k]=32'h1111_1111*(k+1).
// 1. Reset: hold reset_i 2 cycles -> gnt_o=0, valid_o=0, digits_o=0; 1 cycle after release gnt_o still 0.
// 2. Single request:
//    - req_i=4'b0100 -> next edge gnt_o=4'b0100, valid_o=1; following edge digits_o=32'h3333_3333.
//    - Held for 40 cycles with no release.
// 3. Contention, starting from 4'b0100 granted with req_i=4'b0101:
//    - After 3 ticks -> one GAP cycle (gnt_o=0, digits_o=0), then gnt_o=4'b0001.
//    - Next release returns to 4'b0100 (rr wrap).
// 4. Early release: owner 4'b0010 drops req after 1 tick while 4'b1000 waits -> GAP, then gnt_o=4'b1000.
// 5. Simultaneous: owner drops req in the same cycle as tick_en_i -> exactly one GAP, hold_cnt not advanced.
// 6. Reset mid-OWN: assert reset_i during 4'b0001 ownership -> next edge all outputs at reset values, rr_ptr=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package display_pkg;

  localparam int unsigned DIGITS_W = 32;
  localparam int unsigned NIBBLES  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam logic [DIGITS_W-1:0] DEFAULT_IDLE_DIGITS = 32'h0000_0000;

endpackage

// File: rtl/module_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module module_rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0] k;

  // Scan from the far end down so the closest request to ptr is written last.
  always_comb begin
    any_o = |req;
    idx_o = '0;
    k     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (k >= (IDX_W + 1)'(N)) begin
        k = k - (IDX_W + 1)'(N);
      end
      if (req[k[IDX_W-1:0]]) begin
        idx_o = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/module_display_arbiter.sv
// Round-robin owner of the 8-digit display with minimum hold time and a blank gap
// between owners; all outputs are registered.
module module_display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned          N_REQ       = 4,
  parameter int unsigned          HOLD_TICKS  = 10,
  parameter int unsigned          BITS_HOLD   = 4,
  parameter logic [DIGITS_W-1:0]  IDLE_DIGITS = DEFAULT_IDLE_DIGITS
) (
  input  logic                      clk_10Mhz_i,
  input  logic                      reset_i,
  input  logic                      tick_en_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DIGITS_W-1:0] digits_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic                      valid_o,
  output logic [DIGITS_W-1:0]       digits_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [BITS_HOLD-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [DIGITS_W-1:0]  digits_q, digits_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_full;
  logic             others_req;
  logic             release_own;
  logic [IDX_W-1:0] next_ptr;

  module_rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign hold_full   = (hold_cnt_q == BITS_HOLD'(HOLD_TICKS));
  // gnt_q is the owner's one-hot while in OWN, so this masks out the owner.
  assign others_req  = |(req_i & ~gnt_q);
  assign release_own = !req_i[owner_q] || (hold_full && others_req);
  assign next_ptr    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    digits_d   = digits_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d         = OWN;
          owner_d         = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          valid_d         = 1'b1;
          hold_cnt_d      = '0;
        end
      end
      OWN: begin
        // Release takes priority over a coincident tick.
        if (release_own) begin
          state_d  = GAP;
          gnt_d    = '0;
          valid_d  = 1'b0;
          digits_d = IDLE_DIGITS;
          rr_ptr_d = next_ptr;
        end else begin
          digits_d = digits_i[owner_q*DIGITS_W +: DIGITS_W];
          if (tick_en_i && !hold_full) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        valid_d  = 1'b0;
        digits_d = IDLE_DIGITS;
      end
    endcase
  end

  always_ff @(posedge clk_10Mhz_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      digits_q   <= IDLE_DIGITS;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      digits_q   <= digits_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign valid_o  = valid_q;
  assign digits_o = digits_q;

endmodule

// File: tb/tb_module_display_arbiter.sv
// Directed bench for module_display_arbiter: N_REQ=4, HOLD_TICKS=3, tick every 4 clocks.
module tb_module_display_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_en;
  logic [3:0]   req;
  logic [127:0] digits_in;
  logic [3:0]   gnt;
  logic         valid;
  logic [31:0]  digits_out;

  int tests = 0;
  int fails = 0;

  logic tick_auto = 1'b0;
  int   tick_phase = 0;

  assign digits_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  always #50 clk = ~clk;

  module_display_arbiter #(
    .N_REQ       (4),
    .HOLD_TICKS  (3),
    .BITS_HOLD   (2),
    .IDLE_DIGITS (32'h0000_0000)
  ) dut (
    .clk_10Mhz_i (clk),
    .reset_i     (reset),
    .tick_en_i   (tick_en),
    .req_i       (req),
    .digits_i    (digits_in),
    .gnt_o       (gnt),
    .valid_o     (valid),
    .digits_o    (digits_out)
  );

  // Free-running cathode tick, one pulse every 4 clocks, when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_auto) begin
        tick_phase = (tick_phase + 1) % 4;
        tick_en    = (tick_phase == 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b0000; tick_en = 1'b0;
    step(); step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (digits_out !== 32'h0) begin fails++; $display("FAIL reset_digits: got %h want 00000000", digits_out); end
    reset = 1'b0;
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL post_reset_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_single();
    int bad;
    req = 4'b0100; tick_auto = 1'b1;
    step();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", valid); end
    step();
    tests++; if (digits_out !== 32'h3333_3333) begin fails++; $display("FAIL single_digits: got %h want 33333333", digits_out); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt !== 4'b0100 || digits_out !== 32'h3333_3333) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL single_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_contention();
    int n;
    // Owner 2's hold is already saturated, so the new request preempts on the next edge.
    req = 4'b0101;
    step();
    tests++; if (gnt !== 4'b0000 || valid !== 1'b0) begin fails++; $display("FAIL cont_gap_gnt: got %b/%b want 0000/0", gnt, valid); end
    tests++; if (digits_out !== 32'h0) begin fails++; $display("FAIL cont_gap_digits: got %h want 00000000", digits_out); end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL cont_idle_gnt: got %b want 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b0001 || valid !== 1'b1) begin fails++; $display("FAIL cont_gnt0: got %b/%b want 0001/1", gnt, valid); end
    step();
    tests++; if (digits_out !== 32'h1111_1111) begin fails++; $display("FAIL cont_digits0: got %h want 11111111", digits_out); end
    // Owner 0 keeps the display until its third tick, then yields to requester 2.
    n = 1;
    while (n < 30 && gnt === 4'b0001) begin
      step();
      n++;
    end
    tests++; if (gnt !== 4'b0000 || n < 10 || n > 13) begin fails++; $display("FAIL cont_hold_len: got gnt %b after %0d cycles want 0000 after 10..13", gnt, n); end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL cont_gap2: got %b want 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL cont_wrap: got %b want 0100", gnt); end
  endtask

  task automatic test_early_release();
    tick_auto = 1'b0; tick_en = 1'b0;
    req = 4'b0010;
    step(); step(); step();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL early_gnt1: got %b want 0010", gnt); end
    req = 4'b1010; tick_en = 1'b1;
    step();
    tick_en = 1'b0;
    step(); step();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL early_still_owner: got %b want 0010", gnt); end
    req = 4'b1000;
    step();
    tests++; if (gnt !== 4'b0000 || valid !== 1'b0) begin fails++; $display("FAIL early_gap: got %b/%b want 0000/0", gnt, valid); end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL early_idle: got %b want 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL early_gnt3: got %b want 1000", gnt); end
    step();
    tests++; if (digits_out !== 32'h4444_4444) begin fails++; $display("FAIL early_digits3: got %h want 44444444", digits_out); end
  endtask

  task automatic test_simultaneous();
    int bad;
    req = 4'b0100; tick_en = 1'b1;
    step();
    tick_en = 1'b0;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL simul_gap: got %b want 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL simul_idle: got %b want 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL simul_gnt2: got %b want 0100", gnt); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (gnt !== 4'b0100) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL simul_single_gap: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_own();
    // Owner 2 leaves with rr pointer moving to 3; requester 0 then wins by wrap-around.
    req = 4'b0001;
    step(); step(); step();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rmid_gnt0: got %b want 0001", gnt); end
    step();
    tests++; if (digits_out !== 32'h1111_1111) begin fails++; $display("FAIL rmid_digits0: got %h want 11111111", digits_out); end
    reset = 1'b1; req = 4'b1001;
    step();
    tests++; if (gnt !== 4'b0000 || valid !== 1'b0) begin fails++; $display("FAIL rmid_reset_gnt: got %b/%b want 0000/0", gnt, valid); end
    tests++; if (digits_out !== 32'h0) begin fails++; $display("FAIL rmid_reset_digits: got %h want 00000000", digits_out); end
    reset = 1'b0;
    step();
    // rr_ptr back at 0 means requester 0 beats requester 3.
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rmid_ptr_zero: got %b want 0001", gnt); end
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000; tick_en = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_simultaneous();
    test_reset_mid_own();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
